kinase_valve_sequencer: RTL and testbench
=========================================

// Module: kinase_valve_sequencer
// PURPOSE
//  Single command-driven sequencer for the shared, daisy-chained control lines of the kinase_activity array:
//   ctrl_a[12:0], ctrl_s[3:0], pump_a[2:0] and pump_b[1:0].
//  Its outputs drive the ctrl_hole pads. The chain ends at the flush pads.
//  Executes one command at a time: static valve sets, peristaltic pumping, dwell and line flush.
//  Valve encoding: 1 = pressurized (closed), 0 = vented (open).
// PARAMETERS
//  PUMP_DIV     default 1000  clocks per peristaltic phase; must be >= 1
//  FLUSH_CYCLES default 5000  clocks flush_en stays high per FLUSH; must be >= 1
//  ARG_W        default 16    width of cmd_arg and of the cycle/dwell counter
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      async active-low reset
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      sequencer accepts command (combinational: state==IDLE && !abort)
//  cmd_op     in   3      0 NOP, 1 SET_A, 2 SET_S, 3 PUMP_A, 4 PUMP_B, 5 DWELL, 6 FLUSH, 7 illegal
//  cmd_arg    in   ARG_W  SET_A: [12:0] value; SET_S: [3:0] value; PUMP_x: cycle count; DWELL: clocks
//  abort      in   1      return to IDLE immediately
//  ctrl_a     out  13     mux valve lines
//  ctrl_s     out  4      select valve lines
//  pump_a     out  3      3-valve peristaltic pump
//  pump_b     out  2      2-valve pump
//  flush_en   out  1      flush manifold enable
//  busy       out  1      high in any state other than IDLE
//  done       out  1      1-clock pulse when a command completes
//  err        out  1      1-clock pulse when an illegal op is accepted
// BEHAVIOUR
//  Reset values: ctrl_a=0, ctrl_s=0, pump_a=3'b111, pump_b=2'b11, flush_en=0, busy=0, done=0, err=0; state IDLE.
//  Handshake: a command is accepted on the edge where cmd_valid && cmd_ready. Ops and args are captured at that edge.
//  All outputs are registered.
//  FSM states: IDLE, PUMP_A, PUMP_B, DWELL, FLUSH.
//  NOP, SET_A, SET_S, op 7, and any command with arg=0 (PUMP_x, DWELL):
//   - stay in IDLE
//   - the target register updates at the accept edge
//   - done=1 in the following cycle
//   - op 7 also pulses err
//  PUMP_A with arg N>0:
//   - pump_a cycles through the phases 3'b110 -> 3'b101 -> 3'b011, repeating
//   - each phase lasts PUMP_DIV clocks; one pump cycle = 3 phases
//   - the first phase is output from the accept edge
//  PUMP_B with arg N>0:
//   - pump_b alternates 2'b10 -> 2'b01; one cycle = 2 phases
//  DWELL with arg N>0: busy for exactly N clocks, with no output change.
//  FLUSH:
//   - for FLUSH_CYCLES clocks: flush_en=1, and ctrl_a/ctrl_s/pump_a/pump_b are all driven 1
//   - afterwards the prior ctrl_a/ctrl_s values are restored, and the pumps go to idle (all 1)
//  Completion of a timed op:
//   - on the edge its last clock ends, state returns to IDLE, the pump goes to all 1, flush_en=0
//   - done=1 in that cycle, and cmd_ready=1 the same cycle, allowing back-to-back commands
//  Timing: a timed op of T clocks accepted at edge E0 has busy high for cycles E0..E0+T-1 and done in cycle E0+T.
//   - PUMP_A: T = 3*N*PUMP_DIV
//   - PUMP_B: T = 2*N*PUMP_DIV
//  abort:
//   - cmd_ready=0 while abort is high
//   - in any busy state: next edge -> IDLE, pumps 1, flush_en=0, ctrl_a/ctrl_s retained (restored if in FLUSH)
//   - no done pulse on abort; abort in IDLE has no effect
//  Counters:
//   - phase counter is $clog2(PUMP_DIV+1) bits
//   - cycle counter is ARG_W bits and counts down; it never wraps
//   - the flush counter is sized for FLUSH_CYCLES
//  Mid-op async reset: all outputs go to their reset values immediately; the partial command is lost.
//  Unused arg bits are ignored.
// TESTING
//  1. Reset, then SET_A arg=13'h1A5 -> ctrl_a=13'h1A5 and done=1 one clock after accept; ctrl_s=0 unchanged.
//  2. PUMP_DIV=2, PUMP_A arg=2:
//     -> pump_a = 110,110,101,101,011,011 x2 over 12 clocks
//     -> then 111, with done=1 in clock 12; busy high for exactly 12 clocks.
//  3. FLUSH_CYCLES=4 after SET_S=4'h5:
//     -> flush_en=1 and all lines 1 for 4 clocks
//     -> then ctrl_s=4'h5, flush_en=0, done pulse.
//  4. PUMP_B arg=5, abort at clock 3 -> pump_b=11 and busy=0 next clock, no done; next DWELL arg=3 accepted, done after 3 clocks.
//  5. Back-to-back: DWELL 2, then DWELL 0 held valid -> second accepted in the done cycle of the first; its done follows one clock later.
//  6. op 7 -> err and done pulse together, no output change; rst_n low mid-PUMP_A -> pump_a=111 asynchronously.

Source files
------------

// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer: one-command-at-a-time sequencer for the shared
// daisy-chained valve lines of the kinase_activity array.
// It performs static valve sets, peristaltic pumping on two pumps, dwell
// and line flush. Every output is registered.
// Valve encoding: 1 = pressurized (closed), 0 = vented (open).
module kinase_valve_sequencer #(
  parameter int PUMP_DIV     = 1000,  // clocks per peristaltic phase, >= 1
  parameter int FLUSH_CYCLES = 5000,  // clocks flush_en stays high, >= 1
  parameter int ARG_W        = 16     // command argument / cycle counter width, >= 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [ARG_W-1:0] cmd_arg,
  input  logic             abort,
  output logic [12:0]      ctrl_a,
  output logic [3:0]       ctrl_s,
  output logic [2:0]       pump_a,
  output logic [1:0]       pump_b,
  output logic             flush_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PHASE_W = $clog2(PUMP_DIV + 1);
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUMP_A,
    S_PUMP_B,
    S_DWELL,
    S_FLUSH
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_SET_A   = 3'd1,
    OP_SET_S   = 3'd2,
    OP_PUMP_A  = 3'd3,
    OP_PUMP_B  = 3'd4,
    OP_DWELL   = 3'd5,
    OP_FLUSH   = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_cnt_q, phase_cnt_d;   // clocks left in current phase
  logic [1:0]         phase_idx_q, phase_idx_d;   // phase within a pump cycle
  logic [ARG_W-1:0]   cycle_cnt_q, cycle_cnt_d;   // pump cycles / dwell clocks left
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;   // flush clocks left
  logic [12:0]        ctrl_a_val_q, ctrl_a_val_d; // programmed ctrl_a, kept through flush
  logic [3:0]         ctrl_s_val_q, ctrl_s_val_d; // programmed ctrl_s, kept through flush
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [12:0]        ctrl_a_q, ctrl_a_d;
  logic [3:0]         ctrl_s_q, ctrl_s_d;
  logic [2:0]         pump_a_q, pump_a_d;
  logic [1:0]         pump_b_q, pump_b_d;
  logic               flush_en_q, flush_en_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic [1:0]         last_idx;

  assign cmd_ready = (state_q == S_IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;

  assign ctrl_a   = ctrl_a_q;
  assign ctrl_s   = ctrl_s_q;
  assign pump_a   = pump_a_q;
  assign pump_b   = pump_b_q;
  assign flush_en = flush_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

  // State register: FSM state, counters, stored valve values and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop, including the stored valve values, is async-reset so a mid-op reset drops the command cleanly.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_cnt_q  <= '0;
      phase_idx_q  <= '0;
      cycle_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      ctrl_a_val_q <= '0;
      ctrl_s_val_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ctrl_a_q     <= '0;
      ctrl_s_q     <= '0;
      pump_a_q     <= 3'b111;
      pump_b_q     <= 2'b11;
      flush_en_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      phase_idx_q  <= phase_idx_d;
      cycle_cnt_q  <= cycle_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      ctrl_a_val_q <= ctrl_a_val_d;
      ctrl_s_val_q <= ctrl_s_val_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ctrl_a_q     <= ctrl_a_d;
      ctrl_s_q     <= ctrl_s_d;
      pump_a_q     <= pump_a_d;
      pump_b_q     <= pump_b_d;
      flush_en_q   <= flush_en_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic: command decode, phase/cycle/flush counting, completion and abort.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    phase_cnt_d  = phase_cnt_q;
    phase_idx_d  = phase_idx_q;
    cycle_cnt_d  = cycle_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    ctrl_a_val_d = ctrl_a_val_q;
    ctrl_s_val_d = ctrl_s_val_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    last_idx     = (state_q == S_PUMP_A) ? 2'd2 : 2'd1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_NOP: done_d = 1'b1;
            OP_SET_A: begin
              ctrl_a_val_d = cmd_arg[12:0];
              done_d       = 1'b1;
            end
            OP_SET_S: begin
              ctrl_s_val_d = cmd_arg[3:0];
              done_d       = 1'b1;
            end
            OP_PUMP_A, OP_PUMP_B: begin
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                state_d     = (op_e'(cmd_op) == OP_PUMP_A) ? S_PUMP_A : S_PUMP_B;
                cycle_cnt_d = cmd_arg;
                phase_cnt_d = PHASE_W'(PUMP_DIV);
                phase_idx_d = 2'd0;
              end
            end
            OP_DWELL: begin
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                state_d     = S_DWELL;
                cycle_cnt_d = cmd_arg;
              end
            end
            OP_FLUSH: begin
              state_d     = S_FLUSH;
              flush_cnt_d = FLUSH_W'(FLUSH_CYCLES);
            end
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end

      S_PUMP_A, S_PUMP_B: begin
        if (phase_cnt_q == PHASE_W'(1)) begin
          phase_cnt_d = PHASE_W'(PUMP_DIV);
          if (phase_idx_q == last_idx) begin
            phase_idx_d = 2'd0;
            if (cycle_cnt_q == ARG_W'(1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              cycle_cnt_d = cycle_cnt_q - ARG_W'(1);
            end
          end else begin
            phase_idx_d = phase_idx_q + 2'd1;
          end
        end else begin
          phase_cnt_d = phase_cnt_q - PHASE_W'(1);
        end
      end

      S_DWELL: begin
        if (cycle_cnt_q == ARG_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cycle_cnt_d = cycle_cnt_q - ARG_W'(1);
        end
      end

      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over a completion on the same edge and never produces done.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  // Output logic: next values of the registered valve, flush and busy lines.
  always_comb begin
    pump_a_d   = 3'b111;
    pump_b_d   = 2'b11;
    flush_en_d = 1'b0;
    ctrl_a_d   = ctrl_a_val_d;
    ctrl_s_d   = ctrl_s_val_d;
    busy_d     = (state_d != S_IDLE);

    case (state_d)
      S_PUMP_A: begin
        case (phase_idx_d)
          2'd0:    pump_a_d = 3'b110;
          2'd1:    pump_a_d = 3'b101;
          default: pump_a_d = 3'b011;
        endcase
      end
      S_PUMP_B: pump_b_d = (phase_idx_d == 2'd0) ? 2'b10 : 2'b01;
      S_FLUSH: begin
        flush_en_d = 1'b1;
        ctrl_a_d   = '1;
        ctrl_s_d   = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Self-checking bench for kinase_valve_sequencer.
// The driver predicts each command's timing and final valve state from the
// command rules and pushes it into a scoreboard queue; a monitor compares the
// DUT's busy-window waveforms and its done/err pulses against that queue.
module tb_kinase_valve_sequencer;

  localparam int PD    = 2;  // PUMP_DIV
  localparam int FC    = 4;  // FLUSH_CYCLES
  localparam int ARG_W = 16;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_SET_A  = 3'd1;
  localparam logic [2:0] OP_SET_S  = 3'd2;
  localparam logic [2:0] OP_PUMP_A = 3'd3;
  localparam logic [2:0] OP_PUMP_B = 3'd4;
  localparam logic [2:0] OP_DWELL  = 3'd5;
  localparam logic [2:0] OP_FLUSH  = 3'd6;
  localparam logic [2:0] OP_ILL    = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [ARG_W-1:0] cmd_arg;
  logic             abort;
  logic [12:0]      ctrl_a;
  logic [3:0]       ctrl_s;
  logic [2:0]       pump_a;
  logic [1:0]       pump_b;
  logic             flush_en;
  logic             busy;
  logic             done;
  logic             err;

  kinase_valve_sequencer #(
    .PUMP_DIV    (PD),
    .FLUSH_CYCLES(FC),
    .ARG_W       (ARG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .abort    (abort),
    .ctrl_a   (ctrl_a),
    .ctrl_s   (ctrl_s),
    .pump_a   (pump_a),
    .pump_b   (pump_b),
    .flush_en (flush_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Cycle index: after posedge n the DUT is in "cycle n".
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    int          start_c;  // first busy cycle (accept edge)
    int          end_c;    // done cycle, or first idle cycle after abort
    bit          aborted;
    bit          is_err;
    logic [12:0] ca;       // programmed ctrl_a after the command
    logic [3:0]  cs;       // programmed ctrl_s after the command
  } sb_item_t;

  sb_item_t    sb_q[$];
  sb_item_t    mon_it;
  int          n_checks = 0;
  int          n_errors = 0;
  int          free_at  = 0;   // cycle in which the model is idle again
  logic [12:0] m_ctrl_a = '0;
  logic [3:0]  m_ctrl_s = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Busy length of a command in clocks; 0 means it completes at the accept edge.
  function automatic int duration(input logic [2:0] op, input logic [ARG_W-1:0] arg);
    case (op)
      OP_PUMP_A: return 3 * int'(arg) * PD;
      OP_PUMP_B: return 2 * int'(arg) * PD;
      OP_DWELL:  return int'(arg);
      OP_FLUSH:  return FC;
      default:   return 0;
    endcase
  endfunction

  // Expected pump patterns k clocks into a pump command.
  function automatic logic [2:0] exp_pump_a(input logic [2:0] op, input int k);
    logic [2:0] pat [3];
    pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;
    return (op == OP_PUMP_A) ? pat[(k / PD) % 3] : 3'b111;
  endfunction

  function automatic logic [1:0] exp_pump_b(input logic [2:0] op, input int k);
    if (op != OP_PUMP_B) return 2'b11;
    return (((k / PD) % 2) == 0) ? 2'b10 : 2'b01;
  endfunction

  // Monitor: compares busy-window waveforms and pops an entry on done/err or after an abort.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb_q.size() > 0) begin
        mon_it = sb_q[0];
        if (done || err) begin
          check("done_cycle", cyc, mon_it.end_c);
          check("done_level", {31'b0, done}, mon_it.aborted ? 32'd0 : 32'd1);
          check("err", {31'b0, err}, {31'b0, mon_it.is_err});
          check("done_ctrl_a", {19'b0, ctrl_a}, {19'b0, mon_it.ca});
          check("done_ctrl_s", {28'b0, ctrl_s}, {28'b0, mon_it.cs});
          check("done_pumps", {27'b0, pump_a, pump_b}, 32'h1f);
          check("done_flush_busy", {30'b0, flush_en, busy}, 32'd0);
          void'(sb_q.pop_front());
        end else if (cyc >= mon_it.start_c && cyc < mon_it.end_c) begin
          check("run_busy", {31'b0, busy}, 32'd1);
          check("run_pump_a", {29'b0, pump_a}, {29'b0, exp_pump_a(mon_it.op, cyc - mon_it.start_c)});
          check("run_pump_b", {30'b0, pump_b}, {30'b0, exp_pump_b(mon_it.op, cyc - mon_it.start_c)});
          check("run_flush_en", {31'b0, flush_en}, (mon_it.op == OP_FLUSH) ? 32'd1 : 32'd0);
          check("run_ctrl_a", {19'b0, ctrl_a}, (mon_it.op == OP_FLUSH) ? 32'h1fff : {19'b0, mon_it.ca});
          check("run_ctrl_s", {28'b0, ctrl_s}, (mon_it.op == OP_FLUSH) ? 32'hf : {28'b0, mon_it.cs});
        end else if (cyc >= mon_it.end_c) begin
          if (mon_it.aborted) begin
            check("abort_idle", {30'b0, busy, flush_en}, 32'd0);
            check("abort_pumps", {27'b0, pump_a, pump_b}, 32'h1f);
            check("abort_ctrl_a", {19'b0, ctrl_a}, {19'b0, mon_it.ca});
            check("abort_ctrl_s", {28'b0, ctrl_s}, {28'b0, mon_it.cs});
          end else begin
            check("done_missing", {31'b0, done}, 32'd1);
          end
          void'(sb_q.pop_front());
        end
      end else if (done || err) begin
        check("spurious_done_err", {30'b0, done, err}, 32'd0);
      end
    end
  end

  // Offer one command as soon as the model is idle; optionally abort abort_at clocks into it.
  task automatic issue(input logic [2:0] op, input logic [ARG_W-1:0] arg, input int abort_at);
    sb_item_t it;
    int       t;
    int       guard;
    guard = 0;
    while (cyc < free_at && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("issue_wait_timeout", 32'd1, 32'd0);
    #1;
    check("cmd_ready", {31'b0, cmd_ready}, 32'd1);
    t = duration(op, arg);
    if (op == OP_SET_A) m_ctrl_a = arg[12:0];
    if (op == OP_SET_S) m_ctrl_s = arg[3:0];
    it.op      = op;
    it.start_c = cyc + 1;
    it.end_c   = cyc + 1 + t;
    it.aborted = 1'b0;
    it.is_err  = (op == OP_ILL);
    it.ca      = m_ctrl_a;
    it.cs      = m_ctrl_s;
    sb_q.push_back(it);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    free_at   = it.end_c;
    if (abort_at >= 0 && abort_at < t) begin
      repeat (abort_at) @(negedge clk);
      abort = 1'b1;
      it = sb_q.pop_back();
      it.end_c   = cyc + 1;
      it.aborted = 1'b1;
      sb_q.push_back(it);
      free_at = cyc + 1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]       r_op;
    logic [ARG_W-1:0] r_arg;
    int               r_abort;
    int               guard;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl_a", {19'b0, ctrl_a}, 32'd0);
    check("rst_ctrl_s", {28'b0, ctrl_s}, 32'd0);
    check("rst_pump_a", {29'b0, pump_a}, 32'h7);
    check("rst_pump_b", {30'b0, pump_b}, 32'h3);
    check("rst_flags", {28'b0, flush_en, busy, done, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    free_at = cyc;

    // Directed: set with unused high bits, pump A, flush over a set ctrl_s.
    issue(OP_SET_A, 16'hE1A5, -1);
    issue(OP_PUMP_A, 16'd2, -1);
    issue(OP_SET_S, 16'h0005, -1);
    issue(OP_FLUSH, 16'd0, -1);
    // Abort PUMP_B in its third clock, then a dwell.
    issue(OP_PUMP_B, 16'd5, 2);
    issue(OP_DWELL, 16'd3, -1);
    // Back-to-back dwell 2 then dwell 0; illegal op.
    issue(OP_DWELL, 16'd2, -1);
    issue(OP_DWELL, 16'd0, -1);
    issue(OP_ILL, 16'h1234, -1);
    // Abort mid-flush restores ctrl lines; abort on the final pump clock suppresses done.
    issue(OP_FLUSH, 16'd0, 1);
    issue(OP_PUMP_A, 16'd1, 3 * PD - 1);
    issue(OP_PUMP_B, 16'd0, -1);
    issue(OP_NOP, 16'hFFFF, -1);

    // Abort while idle blocks acceptance and changes nothing.
    while (cyc < free_at) @(negedge clk);
    abort = 1'b1; cmd_valid = 1'b1; cmd_op = OP_DWELL; cmd_arg = 16'd5;
    #1;
    check("ready_during_abort", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("idle_abort_busy", {31'b0, busy}, 32'd0);
    abort = 1'b0; cmd_valid = 1'b0;
    free_at = cyc;

    // Randomized commands with occasional aborts.
    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      case (r_op)
        OP_PUMP_A, OP_PUMP_B: r_arg = ARG_W'($urandom_range(0, 3));
        OP_DWELL:             r_arg = ARG_W'($urandom_range(0, 6));
        default:              r_arg = ARG_W'($urandom);
      endcase
      r_abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      issue(r_op, r_arg, r_abort);
    end

    // Asynchronous reset in the middle of a pump command.
    issue(OP_PUMP_A, 16'd3, -1);
    repeat (3) @(negedge clk);
    #2;
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    check("async_rst_pump_a", {29'b0, pump_a}, 32'h7);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_ctrl", {15'b0, ctrl_a, ctrl_s}, 32'd0);
    m_ctrl_a = '0;
    m_ctrl_s = '0;
    @(negedge clk);
    rst_n = 1'b1;
    free_at = cyc;
    @(negedge clk);
    issue(OP_SET_S, 16'h0009, -1);
    issue(OP_DWELL, 16'd1, -1);

    guard = 0;
    while ((sb_q.size() != 0 || cyc < free_at + 2) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
